random_request_arbiter: RTL and testbench

- Shares the single free-running 15-bit pseudo-random word from random_sonya_coin between N_REQ game-logic requesters, e.g. the platform spawner, coin spawner and monster spawner.
- Each requester asks for a uniform value in [0, bound-1].
- Arbitrates round-robin, reduces the word by masked rejection sampling with a capped retry count, and returns the result with a one-cycle ack pulse.

---
 rtl/random_request_arbiter_pkg.sv | 29 ++
 rtl/random_request_arbiter_rr_picker.sv | 31 +++
 rtl/random_request_arbiter.sv | 168 ++++++++++++++++
 tb/tb_random_request_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/random_request_arbiter_pkg.sv
// Shared types, default parameters and helpers for random_request_arbiter.
// Optional statistics outputs are enabled with RANDOM_ARB_STATS_EN.
package random_arb_pkg;

    localparam int unsigned DEF_N_REQ     = 4;
    localparam int unsigned DEF_RAND_W    = 15;
    localparam int unsigned DEF_OUT_W     = 10;
    localparam int unsigned DEF_MAX_RETRY = 4;
    localparam int unsigned BOUND_MAX_W   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        ACK    = 2'd2
    } arb_state_t;

    // Smallest all-ones mask (2^k)-1 with 2^k >= b; 0 and 1 both give mask 0.
    function automatic logic [BOUND_MAX_W-1:0] bound_mask(input logic [BOUND_MAX_W-1:0] b);
        logic [BOUND_MAX_W-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < BOUND_MAX_W; k++) begin
            if ((17'(m) + 17'd1) < 17'(b)) begin
                m = {m[BOUND_MAX_W-2:0], 1'b1};
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/random_request_arbiter_rr_picker.sv
// Combinational round-robin search: first set request bit at or after ptr,
// wrapping modulo N. Reusable for any shared resource.
module rr_picker #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] grant_c,
    output logic             valid_c
);

    int unsigned j;

    always_comb begin
        grant_c = '0;
        valid_c = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid_c && req[IDX_W'(j)]) begin
                valid_c = 1'b1;
                grant_c = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/random_request_arbiter.sv
// Round-robin sharing of a free-running random word; each grant returns a value
// in [0, bound-1] via masked rejection sampling. Stats ports: RANDOM_ARB_STATS_EN.
module random_request_arbiter
    import random_arb_pkg::*;
#(
    parameter  int unsigned N_REQ     = DEF_N_REQ,
    parameter  int unsigned RAND_W    = DEF_RAND_W,
    parameter  int unsigned OUT_W     = DEF_OUT_W,
    parameter  int unsigned MAX_RETRY = DEF_MAX_RETRY,
    localparam int unsigned IDX_W     = $clog2(N_REQ),
    localparam int unsigned RETRY_W   = $clog2(MAX_RETRY) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [RAND_W-1:0]           rand_in,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0][OUT_W-1:0] bound,
    output logic [N_REQ-1:0]            ack,
    output logic [OUT_W-1:0]            rnd_out,
    output logic                        busy
`ifdef RANDOM_ARB_STATS_EN
    ,
    output logic [15:0]                 fallback_cnt,
    output logic [RETRY_W-1:0]          last_retries
`endif
);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [OUT_W-1:0]   bnd_q, bnd_d;
    logic [OUT_W-1:0]   mask_q, mask_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [N_REQ-1:0]   ack_d;
    logic [OUT_W-1:0]   rnd_d;
    logic               busy_d;

    logic [IDX_W-1:0]   pick_idx_c;
    logic               pick_valid_c;
    logic [OUT_W-1:0]   m_c;
    logic               last_try_c;

    rr_picker #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req     (req),
        .ptr     (ptr_q),
        .grant_c (pick_idx_c),
        .valid_c (pick_valid_c)
    );

    assign m_c        = rand_in[OUT_W-1:0] & mask_q;
    assign last_try_c = (retry_q == RETRY_W'(MAX_RETRY - 1));

    generate
        if (RAND_W > OUT_W) begin : g_rand_hi
            logic unused_rand_hi;
            assign unused_rand_hi = ^rand_in[RAND_W-1:OUT_W];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        bnd_d   = bnd_q;
        mask_d  = mask_q;
        retry_d = retry_q;
        rnd_d   = rnd_out;
        ack_d   = '0;

        case (state_q)
            IDLE: begin
                if (pick_valid_c) begin
                    idx_d   = pick_idx_c;
                    bnd_d   = bound[pick_idx_c];
                    mask_d  = OUT_W'(bound_mask(BOUND_MAX_W'(bound[pick_idx_c])));
                    retry_d = '0;
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (bnd_q <= OUT_W'(1)) begin
                    rnd_d   = '0;
                    ack_d   = N_REQ'(1) << idx_q;
                    state_d = ACK;
                end else if (m_c < bnd_q) begin
                    rnd_d   = m_c;
                    ack_d   = N_REQ'(1) << idx_q;
                    state_d = ACK;
                end else if (last_try_c) begin
                    // mask < 2*bound, so m - bound is always inside the range
                    rnd_d   = m_c - bnd_q;
                    ack_d   = N_REQ'(1) << idx_q;
                    state_d = ACK;
                end else begin
                    retry_d = retry_q + RETRY_W'(1);
                end
            end
            ACK: begin
                ptr_d   = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            ptr_q   <= '0;
            bnd_q   <= '0;
            mask_q  <= '0;
            retry_q <= '0;
            ack     <= '0;
            rnd_out <= '0;
            busy    <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            bnd_q   <= bnd_d;
            mask_q  <= mask_d;
            retry_q <= retry_d;
            ack     <= ack_d;
            rnd_out <= rnd_d;
            busy    <= busy_d;
        end
    end

`ifdef RANDOM_ARB_STATS_EN
    logic fallback_c;

    assign fallback_c = (state_q == SAMPLE) && (bnd_q > OUT_W'(1)) &&
                        (m_c >= bnd_q) && last_try_c;

    // Saturating fallback counter and retry count of the last transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            fallback_cnt <= '0;
            last_retries <= '0;
        end else begin
            if (fallback_c && (fallback_cnt != 16'hFFFF)) begin
                fallback_cnt <= fallback_cnt + 16'd1;
            end
            if (state_q == ACK) begin
                last_retries <= retry_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_random_request_arbiter.sv
// Self-checking bench for random_request_arbiter: directed vector table plus
// round-robin, mid-transaction reset and randomised-bound sequences.
module tb_random_request_arbiter;

    localparam int unsigned N_REQ     = 4;
    localparam int unsigned RAND_W    = 15;
    localparam int unsigned OUT_W     = 10;
    localparam int unsigned MAX_RETRY = 4;
    localparam int unsigned LR_W      = $clog2(MAX_RETRY) + 1;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [RAND_W-1:0]           rand_in;
    logic [N_REQ-1:0]            req;
    logic [N_REQ-1:0][OUT_W-1:0] bound;
    logic [N_REQ-1:0]            ack;
    logic [OUT_W-1:0]            rnd_out;
    logic                        busy;
`ifdef RANDOM_ARB_STATS_EN
    logic [15:0]                 fallback_cnt;
    logic [LR_W-1:0]             last_retries;
`endif

    random_request_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .rand_in      (rand_in),
        .req          (req),
        .bound        (bound),
        .ack          (ack),
        .rnd_out      (rnd_out),
        .busy         (busy)
`ifdef RANDOM_ARB_STATS_EN
        ,
        .fallback_cnt (fallback_cnt),
        .last_retries (last_retries)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        int          bnd;
        logic [14:0] r0, r1, r2, r3;
        int          exp_rnd;
        int          exp_lat;
        int          exp_retries;
    } vec_t;

    vec_t vecs[11];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One transaction; inputs change on the falling edge, outputs sampled there too.
    task automatic run_txn(input int idx, input int bnd, input bit rand_mode,
                           input logic [14:0] r0, input logic [14:0] r1,
                           input logic [14:0] r2, input logic [14:0] r3,
                           output int lat, output int got_ack, output int got_rnd,
                           output int busy_s1);
        logic [14:0] rv;
        lat     = 0;
        got_ack = 0;
        got_rnd = -1;
        busy_s1 = 0;
        @(negedge clk);
        req[idx]   = 1'b1;
        bound[idx] = OUT_W'(bnd);
        rand_in    = 15'($urandom);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) busy_s1 = int'(busy);
            if (ack != '0) begin
                lat     = c;
                got_ack = int'(ack);
                got_rnd = int'(rnd_out);
                req[idx] = 1'b0;
                break;
            end
            case (c)
                1:       rv = r0;
                2:       rv = r1;
                3:       rv = r2;
                default: rv = r3;
            endcase
            rand_in = rand_mode ? 15'($urandom) : rv;
        end
        req[idx] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int lat, got_ack, got_rnd, busy_s1, got, bnd, idx;
        int exp_order[5];

        vecs[0]  = '{0,    6, 15'h0003, 15'h0000, 15'h0000, 15'h0000,    3, 2, 0};
        vecs[1]  = '{0,    6, 15'h0007, 15'h0002, 15'h0000, 15'h0000,    2, 3, 1};
        vecs[2]  = '{1,    5, 15'h0007, 15'h0007, 15'h0007, 15'h0007,    2, 5, 3};
        vecs[3]  = '{2,    1, 15'h03FF, 15'h03FF, 15'h03FF, 15'h03FF,    0, 2, 0};
        vecs[4]  = '{3,    0, 15'h0155, 15'h0155, 15'h0155, 15'h0155,    0, 2, 0};
        vecs[5]  = '{2, 1023, 15'h7FFF, 15'h7FFF, 15'h7FFF, 15'h7FFF,    0, 5, 3};
        vecs[6]  = '{1,  512, 15'h7DFF, 15'h0000, 15'h0000, 15'h0000,  511, 2, 0};
        vecs[7]  = '{0,    3, 15'h0003, 15'h0003, 15'h0001, 15'h0000,    1, 4, 2};
        vecs[8]  = '{3,  600, 15'h03FF, 15'h0258, 15'h0257, 15'h0000,  599, 4, 2};
        vecs[9]  = '{2,    2, 15'h03FE, 15'h0000, 15'h0000, 15'h0000,    0, 2, 0};
        vecs[10] = '{1,    5, 15'h0006, 15'h0007, 15'h0005, 15'h0005,    0, 5, 3};
        exp_order = '{0, 1, 2, 3, 0};

        rst     = 1'b1;
        req     = '0;
        bound   = '0;
        rand_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_ack", int'(ack), 0);
        chk("reset_rnd_out", int'(rnd_out), 0);
        chk("reset_busy", int'(busy), 0);
`ifdef RANDOM_ARB_STATS_EN
        chk("reset_fallback_cnt", int'(fallback_cnt), 0);
        chk("reset_last_retries", int'(last_retries), 0);
`endif
        rst = 1'b0;

        foreach (vecs[v]) begin
            run_txn(vecs[v].idx, vecs[v].bnd, 1'b0, vecs[v].r0, vecs[v].r1,
                    vecs[v].r2, vecs[v].r3, lat, got_ack, got_rnd, busy_s1);
            chk($sformatf("vec%0d_busy", v), busy_s1, 1);
            chk($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
            chk($sformatf("vec%0d_ack", v), got_ack, 1 << vecs[v].idx);
            chk($sformatf("vec%0d_rnd_out", v), got_rnd, vecs[v].exp_rnd);
            @(negedge clk);
            chk($sformatf("vec%0d_ack_single", v), int'(ack), 0);
`ifdef RANDOM_ARB_STATS_EN
            chk($sformatf("vec%0d_last_retries", v), int'(last_retries), vecs[v].exp_retries);
`endif
        end
`ifdef RANDOM_ARB_STATS_EN
        chk("fallback_cnt_total", int'(fallback_cnt), 3);
`endif

        // All requesters held; each re-raises the cycle after its ack clears.
        do_reset();
        @(negedge clk);
        bound = '0;
        req   = '1;
        got   = 0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                chk($sformatf("rr_ack%0d", got), int'(ack), 1 << exp_order[got]);
                chk($sformatf("rr_rnd%0d", got), int'(rnd_out), 0);
                req = req & ~ack;
                got++;
            end else begin
                req = '1;
            end
        end
        chk("rr_count", got, 5);
        req = '0;

        // Move rr pointer to 3, then reset while requester 3 is in SAMPLE.
        run_txn(2, 6, 1'b0, 15'h0004, 15'h0, 15'h0, 15'h0, lat, got_ack, got_rnd, busy_s1);
        chk("pre_rst_ack", got_ack, 4);
        @(negedge clk);
        bound[2] = OUT_W'(6);
        bound[3] = OUT_W'(6);
        req      = 4'b1100;
        rand_in  = 15'h0007;
        @(negedge clk);
        chk("mid_busy", int'(busy), 1);
        rand_in = 15'h0007;
        @(negedge clk);
        chk("mid_no_ack", int'(ack), 0);
        rst     = 1'b1;
        rand_in = 15'h0007;
        @(negedge clk);
        chk("mid_rst_ack", int'(ack), 0);
        chk("mid_rst_rnd_out", int'(rnd_out), 0);
        chk("mid_rst_busy", int'(busy), 0);
`ifdef RANDOM_ARB_STATS_EN
        chk("mid_rst_fallback_cnt", int'(fallback_cnt), 0);
`endif
        rst     = 1'b0;
        rand_in = 15'h0003;
        @(negedge clk);
        chk("post_rst_ack_early", int'(ack), 0);
        @(negedge clk);
        chk("post_rst_ack_idx2", int'(ack), 4);
        chk("post_rst_rnd", int'(rnd_out), 3);
        req[2] = 1'b0;
        got    = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk);
            if (ack != '0) begin
                chk("post_rst_ack_idx3", int'(ack), 8);
                chk("post_rst_rnd3", int'(rnd_out), 3);
                got = 1;
            end
        end
        chk("post_rst_idx3_served", got, 1);
        req = '0;

        // Randomised bounds with a random word every cycle.
        for (int t = 0; t < 300; t++) begin
            idx = int'($urandom_range(N_REQ - 1, 0));
            bnd = int'($urandom_range(1023, 1));
            run_txn(idx, bnd, 1'b1, 15'h0, 15'h0, 15'h0, 15'h0, lat, got_ack, got_rnd, busy_s1);
            chk($sformatf("rand%0d_ack", t), got_ack, 1 << idx);
            chk($sformatf("rand%0d_in_range", t), int'(got_rnd >= 0 && got_rnd < bnd), 1);
            chk($sformatf("rand%0d_latency_ok", t), int'(lat >= 2 && lat <= 5), 1);
            @(negedge clk);
            chk($sformatf("rand%0d_ack_single", t), int'(ack), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
